writeback_stage: RTL and testbench

Final pipeline stage of the RISC-V core: accepts completed instructions from execute, waits for load data from the data-memory port, aligns and sign-extends it, and drives the write port of the register file (`write_enabled` / `write_index` / `write_value`). It also drives a same-cycle bypass for decode, because register-file reads are registered and a read issued during a write returns the old value. Misaligned, illegal or timed-out loads are reported as faults, and nothing is written for them.

---
 rtl/writeback_pkg.sv | 23 ++
 rtl/writeback_stage_load_extract.sv | 56 +++++
 rtl/writeback_stage.sv | 163 ++++++++++++++++
 tb/tb_writeback_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared encodings for the writeback stage: instruction kinds, load funct3 codes
// and the FSM state type.
package writeback_pkg;

   typedef enum logic [1:0] {
      KIND_NONE = 2'b00,
      KIND_ALU  = 2'b01,
      KIND_LOAD = 2'b10,
      KIND_RSVD = 2'b11
   } kind_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } state_e;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Load lane selection and sign/zero extension; purely combinational so a future
// load-forwarding path can reuse it. o_fault flags misaligned or illegal funct3.
module load_extract
   import writeback_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_low,
   input  logic [31:0] i_word,
   output logic [31:0] o_value,
   output logic        o_fault
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (i_addr_low)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
   end

   assign w_half = i_addr_low[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_value = 32'h0000_0000;
      o_fault = 1'b0;
      case (i_funct3)
         F3_LB: begin
            o_value = {{24{w_byte[7]}}, w_byte};
         end
         F3_LBU: begin
            o_value = {24'h00_0000, w_byte};
         end
         F3_LH: begin
            o_value = {{16{w_half[15]}}, w_half};
            o_fault = i_addr_low[0];
         end
         F3_LHU: begin
            o_value = {16'h0000, w_half};
            o_fault = i_addr_low[0];
         end
         F3_LW: begin
            o_value = i_word;
            o_fault = (i_addr_low != 2'd0);
         end
         default: begin
            o_fault = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results and loads into the register file,
// with a same-cycle bypass mirror and load-fault reporting.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_IDLE     | ready for a new instruction; ALU/NONE retire next cycle
//   ST_WAIT_MEM | load accepted, waiting for data, bus error or timeout
module writeback_stage
   import writeback_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_kind,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_alu_result,
   input  logic [2:0]  in_funct3,
   input  logic [1:0]  in_addr_low,
   input  logic        mem_rdata_valid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_error,
   output logic        write_enabled,
   output logic [4:0]  write_index,
   output logic [31:0] write_value,
   output logic        bypass_valid,
   output logic [4:0]  bypass_index,
   output logic [31:0] bypass_value,
   output logic        retired,
   output logic        load_fault
);

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_e      r_state;
   logic [7:0]  r_cnt;
   logic [4:0]  r_rd;
   logic [2:0]  r_funct3;
   logic [1:0]  r_addr_low;
   logic        r_in_ready;
   logic        r_wen;
   logic [4:0]  r_widx;
   logic [31:0] r_wval;
   logic        r_retired;
   logic        r_fault;

   logic        w_accept;
   logic        w_waiting;
   logic [2:0]  w_ex_funct3;
   logic [1:0]  w_ex_addr_low;
   logic [31:0] w_ex_value;
   logic        w_ex_fault;

   // r_in_ready is only ever 1 while in ST_IDLE, so it doubles as the accept gate.
   assign w_accept  = in_valid && r_in_ready;
   assign w_waiting = (r_state == ST_WAIT_MEM);

   // One extractor serves both the accept-time fault check and the data return.
   assign w_ex_funct3   = w_waiting ? r_funct3   : in_funct3;
   assign w_ex_addr_low = w_waiting ? r_addr_low : in_addr_low;

   load_extract u_load_extract (
      .i_funct3   (w_ex_funct3),
      .i_addr_low (w_ex_addr_low),
      .i_word     (mem_rdata),
      .o_value    (w_ex_value),
      .o_fault    (w_ex_fault)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 8'd0;
         r_rd       <= 5'd0;
         r_funct3   <= 3'd0;
         r_addr_low <= 2'd0;
         r_in_ready <= 1'b0;
         r_wen      <= 1'b0;
         r_widx     <= 5'd0;
         r_wval     <= 32'h0000_0000;
         r_retired  <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_in_ready <= 1'b1;
         r_wen      <= 1'b0;
         r_widx     <= 5'd0;
         r_wval     <= 32'h0000_0000;
         r_retired  <= 1'b0;
         r_fault    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (in_kind)
                     KIND_ALU: begin
                        r_retired <= 1'b1;
                        if (in_rd != 5'd0) begin
                           r_wen  <= 1'b1;
                           r_widx <= in_rd;
                           r_wval <= in_alu_result;
                        end
                     end
                     KIND_LOAD: begin
                        if (w_ex_fault) begin
                           r_fault   <= 1'b1;
                           r_retired <= 1'b1;
                        end else begin
                           r_rd       <= in_rd;
                           r_funct3   <= in_funct3;
                           r_addr_low <= in_addr_low;
                           r_cnt      <= 8'd0;
                           r_in_ready <= 1'b0;
                           r_state    <= ST_WAIT_MEM;
                        end
                     end
                     default: begin
                        r_retired <= 1'b1;
                     end
                  endcase
               end
            end
            ST_WAIT_MEM: begin
               if (mem_error) begin
                  r_fault   <= 1'b1;
                  r_retired <= 1'b1;
                  r_state   <= ST_IDLE;
               end else if (mem_rdata_valid) begin
                  r_retired <= 1'b1;
                  if (r_rd != 5'd0) begin
                     r_wen  <= 1'b1;
                     r_widx <= r_rd;
                     r_wval <= w_ex_value;
                  end
                  r_state <= ST_IDLE;
               end else if (r_cnt == TIMEOUT) begin
                  r_fault   <= 1'b1;
                  r_retired <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_cnt      <= r_cnt + 8'd1;
                  r_in_ready <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign write_enabled = r_wen;
   assign write_index   = r_widx;
   assign write_value   = r_wval;
   assign bypass_valid  = r_wen;
   assign bypass_index  = r_widx;
   assign bypass_value  = r_wval;
   assign retired       = r_retired;
   assign load_fault    = r_fault;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a table of single-instruction vectors plus
// hand-written multi-cycle sequences (back-to-back ALU, timeout, bus error, reset).
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind;
   logic [4:0]  in_rd;
   logic [31:0] in_alu_result;
   logic [2:0]  in_funct3;
   logic [1:0]  in_addr_low;
   logic        mem_rdata_valid;
   logic [31:0] mem_rdata;
   logic        mem_error;
   logic        write_enabled;
   logic [4:0]  write_index;
   logic [31:0] write_value;
   logic        bypass_valid;
   logic [4:0]  bypass_index;
   logic [31:0] bypass_value;
   logic        retired;
   logic        load_fault;

   int n_checks = 0;
   int n_errors = 0;

   writeback_stage #(.MEM_TIMEOUT(4)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_kind         (in_kind),
      .in_rd           (in_rd),
      .in_alu_result   (in_alu_result),
      .in_funct3       (in_funct3),
      .in_addr_low     (in_addr_low),
      .mem_rdata_valid (mem_rdata_valid),
      .mem_rdata       (mem_rdata),
      .mem_error       (mem_error),
      .write_enabled   (write_enabled),
      .write_index     (write_index),
      .write_value     (write_value),
      .bypass_valid    (bypass_valid),
      .bypass_index    (bypass_index),
      .bypass_value    (bypass_value),
      .retired         (retired),
      .load_fault      (load_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [2:0]  f3;
      logic [1:0]  addr;
      logic [31:0] word;
      logic        mem;
      logic        exp_wen;
      logic [31:0] exp_val;
      logic        exp_fault;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(logic [1:0] kind, logic [4:0] rd, logic [31:0] alu,
                               logic [2:0] f3, logic [1:0] addr, logic [31:0] word,
                               logic mem, logic exp_wen, logic [31:0] exp_val,
                               logic exp_fault);
      vec_t v;
      v.kind = kind; v.rd = rd; v.alu = alu; v.f3 = f3; v.addr = addr; v.word = word;
      v.mem = mem; v.exp_wen = exp_wen; v.exp_val = exp_val; v.exp_fault = exp_fault;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_bypass(input string name);
      chk({name, "_byp_v"}, bypass_valid, write_enabled);
      chk({name, "_byp_i"}, bypass_index, write_index);
      chk({name, "_byp_d"}, bypass_value, write_value);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_wen"}, write_enabled, 1'b0);
      chk({name, "_ret"}, retired, 1'b0);
      chk({name, "_flt"}, load_fault, 1'b0);
   endtask

   task automatic offer(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [2:0] f3, input logic [1:0] addr);
      in_valid = 1'b1; in_kind = kind; in_rd = rd; in_alu_result = alu;
      in_funct3 = f3; in_addr_low = addr;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string nm;
      nm = $sformatf("vec%0d", idx);
      chk({nm, "_rdy_pre"}, in_ready, 1'b1);
      offer(v.kind, v.rd, v.alu, v.f3, v.addr);
      tick();
      in_valid = 1'b0;
      if (v.mem) begin
         chk({nm, "_rdy_wait"}, in_ready, 1'b0);
         chk_quiet({nm, "_wait"});
         mem_rdata_valid = 1'b1;
         mem_rdata = v.word;
         tick();
         mem_rdata_valid = 1'b0;
      end
      chk({nm, "_wen"}, write_enabled, v.exp_wen);
      chk({nm, "_idx"}, write_index, v.exp_wen ? 32'(v.rd) : 32'd0);
      chk({nm, "_val"}, write_value, v.exp_val);
      chk({nm, "_ret"}, retired, 1'b1);
      chk({nm, "_flt"}, load_fault, v.exp_fault);
      chk({nm, "_rdy"}, in_ready, 1'b1);
      chk_bypass(nm);
      tick();
      chk_quiet({nm, "_after"});
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_kind = 2'b00; in_rd = 5'd0;
      in_alu_result = 32'h0; in_funct3 = 3'b000; in_addr_low = 2'b00;
      mem_rdata_valid = 1'b0; mem_rdata = 32'h0; mem_error = 1'b0;

      //            kind   rd     alu           f3      addr   word          mem  wen  value         flt
      vecs[0]  = mk(2'b01, 5'd7,  32'h12345678, 3'b000, 2'd0, 32'h0,        0,   1,   32'h12345678, 0);
      vecs[1]  = mk(2'b01, 5'd0,  32'hFFFFFFFF, 3'b000, 2'd0, 32'h0,        0,   0,   32'h0,        0);
      vecs[2]  = mk(2'b00, 5'd9,  32'hAAAA5555, 3'b000, 2'd0, 32'h0,        0,   0,   32'h0,        0);
      vecs[3]  = mk(2'b11, 5'd3,  32'h5555AAAA, 3'b000, 2'd0, 32'h0,        0,   0,   32'h0,        0);
      vecs[4]  = mk(2'b10, 5'd4,  32'h0,        3'b000, 2'd3, 32'h80FF0000, 1,   1,   32'hFFFFFF80, 0);
      vecs[5]  = mk(2'b10, 5'd4,  32'h0,        3'b100, 2'd3, 32'h80FF0000, 1,   1,   32'h00000080, 0);
      vecs[6]  = mk(2'b10, 5'd10, 32'h0,        3'b000, 2'd1, 32'h00007F00, 1,   1,   32'h0000007F, 0);
      vecs[7]  = mk(2'b10, 5'd11, 32'h0,        3'b001, 2'd2, 32'h80011234, 1,   1,   32'hFFFF8001, 0);
      vecs[8]  = mk(2'b10, 5'd11, 32'h0,        3'b101, 2'd2, 32'h80011234, 1,   1,   32'h00008001, 0);
      vecs[9]  = mk(2'b10, 5'd12, 32'h0,        3'b001, 2'd0, 32'h0000ABCD, 1,   1,   32'hFFFFABCD, 0);
      vecs[10] = mk(2'b10, 5'd31, 32'h0,        3'b010, 2'd0, 32'hCAFEBABE, 1,   1,   32'hCAFEBABE, 0);
      vecs[11] = mk(2'b10, 5'd13, 32'h0,        3'b001, 2'd1, 32'h0,        0,   0,   32'h0,        1);
      vecs[12] = mk(2'b10, 5'd13, 32'h0,        3'b010, 2'd2, 32'h0,        0,   0,   32'h0,        1);
      vecs[13] = mk(2'b10, 5'd14, 32'h0,        3'b011, 2'd0, 32'h0,        0,   0,   32'h0,        1);
      vecs[14] = mk(2'b10, 5'd14, 32'h0,        3'b110, 2'd0, 32'h0,        0,   0,   32'h0,        1);
      vecs[15] = mk(2'b10, 5'd14, 32'h0,        3'b111, 2'd0, 32'h0,        0,   0,   32'h0,        1);
      vecs[16] = mk(2'b10, 5'd0,  32'h0,        3'b010, 2'd0, 32'h11111111, 1,   0,   32'h0,        0);
      vecs[17] = mk(2'b10, 5'd1,  32'h0,        3'b000, 2'd2, 32'h00AB0000, 1,   1,   32'hFFFFFFAB, 0);

      // reset state
      tick();
      tick();
      chk("rst_rdy", in_ready, 1'b0);
      chk_quiet("rst");
      chk("rst_idx", write_index, 32'd0);
      chk("rst_val", write_value, 32'd0);
      reset_n = 1'b1;
      tick();
      chk("rel_rdy", in_ready, 1'b1);

      for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

      // three ALU results back-to-back
      offer(2'b01, 5'd5, 32'hDEADBEEF, 3'b000, 2'd0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b2b%0d_rdy", i), in_ready, 1'b1);
         tick();
         chk($sformatf("b2b%0d_wen", i), write_enabled, 1'b1);
         chk($sformatf("b2b%0d_idx", i), write_index, 32'd5);
         chk($sformatf("b2b%0d_val", i), write_value, 32'hDEADBEEF);
         chk($sformatf("b2b%0d_ret", i), retired, 1'b1);
         chk_bypass($sformatf("b2b%0d", i));
      end
      in_valid = 1'b0;
      tick();
      chk_quiet("b2b_end");
      chk_bypass("b2b_end");

      // timeout with MEM_TIMEOUT=4: five waiting cycles, fault pulse after the fifth
      offer(2'b10, 5'd6, 32'h0, 3'b010, 2'd0);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("to_w%0d_rdy", k), in_ready, 1'b0);
         chk_quiet($sformatf("to_w%0d", k));
         if (k < 5) tick();
      end
      tick();
      chk("to_flt", load_fault, 1'b1);
      chk("to_ret", retired, 1'b1);
      chk("to_wen", write_enabled, 1'b0);
      chk("to_rdy", in_ready, 1'b1);
      mem_rdata_valid = 1'b1;
      mem_rdata = 32'h77777777;
      tick();
      mem_rdata_valid = 1'b0;
      chk_quiet("late");
      chk("late_rdy", in_ready, 1'b1);

      // bus error wins over simultaneous data
      offer(2'b10, 5'd8, 32'h0, 3'b000, 2'd0);
      tick();
      in_valid = 1'b0;
      mem_error = 1'b1;
      mem_rdata_valid = 1'b1;
      mem_rdata = 32'h000000FF;
      tick();
      mem_error = 1'b0;
      mem_rdata_valid = 1'b0;
      chk("err_flt", load_fault, 1'b1);
      chk("err_ret", retired, 1'b1);
      chk("err_wen", write_enabled, 1'b0);
      tick();
      chk_quiet("err_after");

      // reset while waiting abandons the load
      offer(2'b10, 5'd2, 32'h0, 3'b010, 2'd0);
      tick();
      in_valid = 1'b0;
      chk("rw_rdy_wait", in_ready, 1'b0);
      reset_n = 1'b0;
      tick();
      chk("rw_rdy", in_ready, 1'b0);
      chk_quiet("rw_in_rst");
      mem_rdata_valid = 1'b1;
      mem_rdata = 32'h12121212;
      tick();
      reset_n = 1'b1;
      tick();
      mem_rdata_valid = 1'b0;
      chk_quiet("rw_post");
      chk("rw_idx", write_index, 32'd0);
      chk("rw_val", write_value, 32'd0);
      chk("rw_rdy_idle", in_ready, 1'b1);
      tick();
      chk_quiet("rw_post2");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
